// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU-to-physical-memory bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } lsu_size_e;

    // MMIO window; accesses inside it are flagged so difftest can skip them.
    localparam logic [63:0] DEV_BASE     = 64'h0000_0000_a000_0000;
    localparam logic [63:0] DEV_LIMIT    = 64'h0000_0000_a1ff_ffff;

    localparam logic [63:0] MMIO_TIMER   = 64'h0000_0000_a000_0048;
    localparam logic [63:0] MMIO_SERIAL  = 64'h0000_0000_a000_03f8;
    localparam logic [63:0] MMIO_VGA_CTL = 64'h0000_0000_a000_0100;
    localparam logic [63:0] MMIO_FB      = 64'h0000_0000_a100_0000;

    // Byte lanes touched by an access of the given size, before shifting.
    function automatic logic [7:0] size_lanes(input lsu_size_e sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_align(input lsu_size_e sz);
        case (sz)
            SZ_B:    return 3'd0;
            SZ_H:    return 3'd1;
            SZ_W:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/lsu_pmem_bridge_if.sv
// LSU request/response handshake plus the memory-model strobe bus.
// Latency: n/a (wires only).
// Backpressure: req_ready / resp_ready carried here.
interface lsu_pmem_bridge_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [63:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_rdata;
    logic              resp_misalign;
    logic              resp_device;

    logic [63:0]       pmem_raddr;
    logic              pmem_rvalid;
    logic [63:0]       pmem_rdata;
    logic [63:0]       pmem_waddr;
    logic [63:0]       pmem_wdata;
    logic [7:0]        pmem_mask;

    // Environment side: LSU issues requests, memory model returns read data.
    modport master (
        output req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata,
        output resp_ready, pmem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_device,
        input  pmem_raddr, pmem_rvalid, pmem_waddr, pmem_wdata, pmem_mask
    );

    // Bridge side.
    modport slave (
        input  req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata,
        input  resp_ready, pmem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign, resp_device,
        output pmem_raddr, pmem_rvalid, pmem_waddr, pmem_wdata, pmem_mask
    );
endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed bytes from a dword and sign/zero-extends them.
// Latency: combinational.
// Backpressure: none.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [2:0]  offset_i,
    input  lsu_size_e   size_i,
    input  logic        unsigned_i,
    output logic [63:0] data_o
);
    logic [63:0] raw;

    // Shift the addressed byte to lane 0, then extend from the access width.
    always_comb begin
        raw    = data_i >> {offset_i, 3'b000};
        data_o = raw;
        case (size_i)
            SZ_B:    data_o = unsigned_i ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            SZ_H:    data_o = unsigned_i ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            SZ_W:    data_o = unsigned_i ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: data_o = raw;
        endcase
    end
endmodule

// File: rtl/lsu_pmem_bridge.sv
// Converts one LSU load/store at a time into memory-model strobes, with MMIO flagging.
// Latency: accept at t -> ACCESS at t+1 -> resp_valid at t+1+LATENCY (misaligned: t+1).
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
module lsu_pmem_bridge
    import lsu_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    lsu_pmem_bridge_if.slave   bus
);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    lsu_size_e         size_q, size_d;
    logic              uns_q, uns_d;
    logic              mis_q, mis_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [63:0]       rcap_q, rcap_d;
    logic [63:0]       raddr_q, raddr_d;
    logic [63:0]       waddr_q, waddr_d;
    logic [63:0]       pwdata_q, pwdata_d;
    logic [7:0]        mask_q, mask_d;
    logic              rvalid_q, rvalid_d;

    lsu_size_e         req_sz;
    logic              req_mis;
    logic [63:0]       req_line;
    logic              in_resp;
    logic              in_dev;
    logic [63:0]       ld_data;

    assign req_sz   = lsu_size_e'(bus.req_size);
    assign req_mis  = (bus.req_addr[2:0] & size_align(req_sz)) != 3'b000;
    assign req_line = 64'({bus.req_addr[ADDR_W-1:3], 3'b000});
    assign in_resp  = (state_q == ST_RESP);
    assign in_dev   = (addr_q >= ADDR_W'(DEV_BASE)) && (addr_q <= ADDR_W'(DEV_LIMIT));

    lsu_load_align u_align (
        .data_i     (rcap_q),
        .offset_i   (addr_q[2:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ld_data)
    );

    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.resp_valid    = in_resp;
    assign bus.resp_misalign = in_resp && mis_q;
    assign bus.resp_device   = in_resp && in_dev;
    assign bus.resp_rdata    = (in_resp && !wen_q && !mis_q) ? ld_data : 64'b0;

    assign bus.pmem_raddr    = raddr_q;
    assign bus.pmem_waddr    = waddr_q;
    assign bus.pmem_wdata    = pwdata_q;
    assign bus.pmem_mask     = mask_q;
    assign bus.pmem_rvalid   = rvalid_q;

    // Next state. The memory model acts on any change of mask/rvalid, so both are
    // computed one cycle ahead and are nonzero only for the single ACCESS cycle.
    // Store data is lane-shifted at accept time; pwdata_q is the latched copy.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        size_d   = size_q;
        uns_d    = uns_q;
        mis_d    = mis_q;
        cnt_d    = cnt_q;
        rcap_d   = rcap_q;
        raddr_d  = raddr_q;
        waddr_d  = waddr_q;
        pwdata_d = pwdata_q;
        mask_d   = 8'h00;
        rvalid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    wen_d  = bus.req_wen;
                    size_d = req_sz;
                    uns_d  = bus.req_unsigned;
                    mis_d  = req_mis;
                    if (req_mis) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACCESS;
                        raddr_d = req_line;
                        waddr_d = req_line;
                        if (bus.req_wen) begin
                            mask_d   = size_lanes(req_sz) << bus.req_addr[2:0];
                            pwdata_d = bus.req_wdata << {bus.req_addr[2:0], 3'b000};
                        end else begin
                            rvalid_d = 1'b1;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (!wen_q) begin
                    rcap_d = bus.pmem_rdata;
                end
                if (LATENCY == 1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_INIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight access at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            size_q   <= SZ_B;
            uns_q    <= 1'b0;
            mis_q    <= 1'b0;
            cnt_q    <= 4'd0;
            rcap_q   <= 64'b0;
            raddr_q  <= 64'b0;
            waddr_q  <= 64'b0;
            pwdata_q <= 64'b0;
            mask_q   <= 8'h00;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            mis_q    <= mis_d;
            cnt_q    <= cnt_d;
            rcap_q   <= rcap_d;
            raddr_q  <= raddr_d;
            waddr_q  <= waddr_d;
            pwdata_q <= pwdata_d;
            mask_q   <= mask_d;
            rvalid_q <= rvalid_d;
        end
    end
endmodule

// File: tb/tb_lsu_pmem_bridge.sv
// Bench for lsu_pmem_bridge: vector table on a LATENCY=1 instance, plus
// hand sequences for backpressure and reset on a LATENCY=4 instance.
// Memory read data is driven directly per transaction.
module tb_lsu_pmem_bridge;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    lsu_pmem_bridge_if #(.ADDR_W(64)) bus1 ();
    lsu_pmem_bridge_if #(.ADDR_W(64)) bus4 ();

    lsu_pmem_bridge #(.LATENCY(1), .ADDR_W(64)) u_l1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    lsu_pmem_bridge #(.LATENCY(4), .ADDR_W(64)) u_l4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] wdata;
        logic [63:0] mem;
        logic [63:0] raddr;
        logic [7:0]  mask;
        logic [63:0] pwdata;
        logic [63:0] rdata;
        logic        mis;
        logic        dev;
        int          lat;
    } vec_t;

    vec_t vt[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                                input logic uns, input logic [63:0] wdata, input logic [63:0] mem,
                                input logic [63:0] raddr, input logic [7:0] mask,
                                input logic [63:0] pwdata, input logic [63:0] rdata,
                                input logic mis, input logic dev);
        vec_t v;
        v.addr = addr; v.wen = wen; v.size = size; v.uns = uns; v.wdata = wdata; v.mem = mem;
        v.raddr = raddr; v.mask = mask; v.pwdata = pwdata; v.rdata = rdata;
        v.mis = mis; v.dev = dev;
        v.lat = mis ? 1 : 2;
        return v;
    endfunction

    task automatic drive_req(input bit four, input logic [63:0] addr, input logic wen,
                             input logic [1:0] size, input logic uns, input logic [63:0] wdata);
        if (four) begin
            bus4.req_valid = 1'b1; bus4.req_addr = addr; bus4.req_wen = wen;
            bus4.req_size = size; bus4.req_unsigned = uns; bus4.req_wdata = wdata;
        end else begin
            bus1.req_valid = 1'b1; bus1.req_addr = addr; bus1.req_wen = wen;
            bus1.req_size = size; bus1.req_unsigned = uns; bus1.req_wdata = wdata;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0; bit seen = 0; int rv_n = 0; int mk_n = 0;
        logic [63:0] a_raddr = 64'b0, a_waddr = 64'b0, a_wdata = 64'b0;
        logic [7:0]  a_mask = 8'h00;
        @(negedge clock);
        drive_req(1'b0, v.addr, v.wen, v.size, v.uns, v.wdata);
        bus1.pmem_rdata = v.mem;
        @(posedge clock); #1;
        bus1.req_valid = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (bus1.pmem_rvalid) begin rv_n++; a_raddr = bus1.pmem_raddr; end
            if (bus1.pmem_mask != 8'h00) begin
                mk_n++; a_mask = bus1.pmem_mask; a_wdata = bus1.pmem_wdata; a_waddr = bus1.pmem_waddr;
            end
            if (bus1.resp_valid) seen = 1;
        end
        chk($sformatf("v%0d.seen", idx), 64'(seen), 64'd1);
        chk($sformatf("v%0d.lat", idx), 64'(cyc), 64'(v.lat));
        chk($sformatf("v%0d.rvalid_cycles", idx), 64'(rv_n), (!v.wen && !v.mis) ? 64'd1 : 64'd0);
        chk($sformatf("v%0d.mask_cycles", idx), 64'(mk_n), (v.wen && !v.mis) ? 64'd1 : 64'd0);
        chk($sformatf("v%0d.mask", idx), 64'(a_mask), 64'(v.mask));
        if (!v.wen && !v.mis) chk($sformatf("v%0d.raddr", idx), a_raddr, v.raddr);
        if (v.wen && !v.mis) begin
            chk($sformatf("v%0d.waddr", idx), a_waddr, v.raddr);
            chk($sformatf("v%0d.wdata", idx), a_wdata, v.pwdata);
        end
        chk($sformatf("v%0d.rdata", idx), bus1.resp_rdata, v.rdata);
        chk($sformatf("v%0d.misalign", idx), 64'(bus1.resp_misalign), 64'(v.mis));
        chk($sformatf("v%0d.device", idx), 64'(bus1.resp_device), 64'(v.dev));
        chk($sformatf("v%0d.busy_ready", idx), 64'(bus1.req_ready), 64'd0);
        bus1.resp_ready = 1'b1;
        @(posedge clock); #1;
        bus1.resp_ready = 1'b0;
        @(negedge clock);
        chk($sformatf("v%0d.ready_after", idx), 64'(bus1.req_ready), 64'd1);
        chk($sformatf("v%0d.valid_after", idx), 64'(bus1.resp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc; bit seen; int rv_n; int mk_n; int rdy_bad; int rv_cnt;
        logic [63:0] a_raddr;

        bus1.req_valid = 0; bus1.req_addr = 0; bus1.req_wen = 0; bus1.req_size = 0;
        bus1.req_unsigned = 0; bus1.req_wdata = 0; bus1.resp_ready = 0; bus1.pmem_rdata = 0;
        bus4.req_valid = 0; bus4.req_addr = 0; bus4.req_wen = 0; bus4.req_size = 0;
        bus4.req_unsigned = 0; bus4.req_wdata = 0; bus4.resp_ready = 0; bus4.pmem_rdata = 0;

        //       addr                wen   sz    uns   wdata                   mem                     raddr                   mask   pwdata                  rdata                   mis   dev
        vt.push_back(mk(64'h80000003, 1'b0, 2'd0, 1'b1, 64'h0,                 64'h00000000_80FF0000, 64'h80000000,          8'h00, 64'h0,                 64'h00000000_00000080, 1'b0, 1'b0));
        vt.push_back(mk(64'h80000003, 1'b0, 2'd0, 1'b0, 64'h0,                 64'h00000000_80FF0000, 64'h80000000,          8'h00, 64'h0,                 64'hFFFFFFFF_FFFFFF80, 1'b0, 1'b0));
        vt.push_back(mk(64'h80000006, 1'b1, 2'd1, 1'b0, 64'hABCD,              64'h0,                 64'h80000000,          8'hC0, 64'hABCD0000_00000000, 64'h0,                 1'b0, 1'b0));
        vt.push_back(mk(64'h80000002, 1'b0, 2'd2, 1'b0, 64'h0,                 64'h12345678_9ABCDEF0, 64'h0,                 8'h00, 64'h0,                 64'h0,                 1'b1, 1'b0));
        vt.push_back(mk(64'h80000010, 1'b0, 2'd3, 1'b0, 64'h0,                 64'h11223344_55667788, 64'h80000010,          8'h00, 64'h0,                 64'h11223344_55667788, 1'b0, 1'b0));
        vt.push_back(mk(64'h80000004, 1'b0, 2'd2, 1'b0, 64'h0,                 64'h87654321_00000000, 64'h80000000,          8'h00, 64'h0,                 64'hFFFFFFFF_87654321, 1'b0, 1'b0));
        vt.push_back(mk(64'h80000006, 1'b0, 2'd1, 1'b1, 64'h0,                 64'hBEEF0000_00000000, 64'h80000000,          8'h00, 64'h0,                 64'h00000000_0000BEEF, 1'b0, 1'b0));
        vt.push_back(mk(64'h80000002, 1'b0, 2'd1, 1'b0, 64'h0,                 64'h00000000_7FFF0000, 64'h80000000,          8'h00, 64'h0,                 64'h00000000_00007FFF, 1'b0, 1'b0));
        vt.push_back(mk(64'h80000008, 1'b0, 2'd3, 1'b1, 64'h0,                 64'hF0000000_00000001, 64'h80000008,          8'h00, 64'h0,                 64'hF0000000_00000001, 1'b0, 1'b0));
        vt.push_back(mk(64'h80000007, 1'b0, 2'd0, 1'b0, 64'h0,                 64'h7F000000_00000000, 64'h80000000,          8'h00, 64'h0,                 64'h00000000_0000007F, 1'b0, 1'b0));
        vt.push_back(mk(64'h80000004, 1'b1, 2'd2, 1'b0, 64'hCAFEBABE,          64'h0,                 64'h80000000,          8'hF0, 64'hCAFEBABE_00000000, 64'h0,                 1'b0, 1'b0));
        vt.push_back(mk(64'ha00003f8, 1'b1, 2'd3, 1'b0, 64'h01234567_89ABCDEF, 64'h0,                 64'ha00003f8,          8'hFF, 64'h01234567_89ABCDEF, 64'h0,                 1'b0, 1'b1));
        vt.push_back(mk(64'ha0000001, 1'b1, 2'd0, 1'b0, 64'h5A,                64'h0,                 64'ha0000000,          8'h02, 64'h00000000_00005A00, 64'h0,                 1'b0, 1'b1));
        vt.push_back(mk(64'h80000001, 1'b1, 2'd1, 1'b0, 64'h1234,              64'h0,                 64'h0,                 8'h00, 64'h0,                 64'h0,                 1'b1, 1'b0));
        vt.push_back(mk(64'ha1000006, 1'b0, 2'd2, 1'b0, 64'h0,                 64'hFFFFFFFF_FFFFFFFF, 64'h0,                 8'h00, 64'h0,                 64'h0,                 1'b1, 1'b1));
        vt.push_back(mk(64'ha1fffff8, 1'b0, 2'd3, 1'b0, 64'h0,                 64'h42,                64'ha1fffff8,          8'h00, 64'h0,                 64'h42,                1'b0, 1'b1));
        vt.push_back(mk(64'h9ffffff8, 1'b0, 2'd3, 1'b0, 64'h0,                 64'h7,                 64'h9ffffff8,          8'h00, 64'h0,                 64'h7,                 1'b0, 1'b0));
        vt.push_back(mk(64'ha2000000, 1'b0, 2'd0, 1'b0, 64'h0,                 64'hFF,                64'ha2000000,          8'h00, 64'h0,                 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0));

        // Reset values.
        repeat (3) @(negedge clock);
        chk("rst.req_ready", 64'(bus1.req_ready), 64'd1);
        chk("rst.resp_valid", 64'(bus1.resp_valid), 64'd0);
        chk("rst.misalign", 64'(bus1.resp_misalign), 64'd0);
        chk("rst.device", 64'(bus1.resp_device), 64'd0);
        chk("rst.rvalid", 64'(bus1.pmem_rvalid), 64'd0);
        chk("rst.mask", 64'(bus1.pmem_mask), 64'd0);
        chk("rst.raddr", bus1.pmem_raddr, 64'd0);
        chk("rst.waddr", bus1.pmem_waddr, 64'd0);
        chk("rst.wdata", bus1.pmem_wdata, 64'd0);
        chk("rst.rdata", bus1.resp_rdata, 64'd0);
        chk("rst4.req_ready", 64'(bus4.req_ready), 64'd1);
        reset_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

        // LATENCY=4 timer load with response backpressure and a request while busy.
        @(negedge clock);
        drive_req(1'b1, 64'ha0000048, 1'b0, 2'd3, 1'b0, 64'h0);
        bus4.pmem_rdata = 64'hDEADBEEF_CAFEF00D;
        @(posedge clock); #1;
        bus4.req_valid = 1'b0;
        cyc = 0; seen = 0; rv_n = 0; mk_n = 0; rdy_bad = 0; a_raddr = 64'b0;
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (bus4.pmem_rvalid) begin rv_n++; a_raddr = bus4.pmem_raddr; end
            if (bus4.pmem_mask != 8'h00) mk_n++;
            if (bus4.req_ready) rdy_bad++;
            if (cyc == 2) begin
                bus4.pmem_rdata = 64'h0;
                drive_req(1'b1, 64'h80000000, 1'b1, 2'd3, 1'b0, 64'h1111);
            end
            if (bus4.resp_valid) seen = 1;
        end
        bus4.req_valid = 1'b0;
        chk("l4.lat", 64'(cyc), 64'd5);
        chk("l4.rvalid_cycles", 64'(rv_n), 64'd1);
        chk("l4.raddr", a_raddr, 64'ha0000048);
        chk("l4.mask_cycles", 64'(mk_n), 64'd0);
        chk("l4.ready_while_busy", 64'(rdy_bad), 64'd0);
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clock);
            chk($sformatf("l4.hold%0d.valid", j), 64'(bus4.resp_valid), 64'd1);
            chk($sformatf("l4.hold%0d.rdata", j), bus4.resp_rdata, 64'hDEADBEEF_CAFEF00D);
            chk($sformatf("l4.hold%0d.device", j), 64'(bus4.resp_device), 64'd1);
            chk($sformatf("l4.hold%0d.ready", j), 64'(bus4.req_ready), 64'd0);
            chk($sformatf("l4.hold%0d.mask", j), 64'(bus4.pmem_mask), 64'd0);
        end
        bus4.resp_ready = 1'b1;
        @(posedge clock); #1;
        bus4.resp_ready = 1'b0;
        @(negedge clock);
        chk("l4.ready_after", 64'(bus4.req_ready), 64'd1);
        chk("l4.valid_after", 64'(bus4.resp_valid), 64'd0);
        chk("l4.mask_after", 64'(bus4.pmem_mask), 64'd0);

        // Store on LATENCY=4, reset pulled during WAIT.
        @(negedge clock);
        drive_req(1'b1, 64'h80000000, 1'b1, 2'd3, 1'b0, 64'h55555555_55555555);
        @(posedge clock); #1;
        bus4.req_valid = 1'b0;
        @(negedge clock);
        chk("rw.access_mask", 64'(bus4.pmem_mask), 64'hFF);
        @(negedge clock);
        chk("rw.wait_mask", 64'(bus4.pmem_mask), 64'd0);
        chk("rw.wait_valid", 64'(bus4.resp_valid), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("rw.rst_ready", 64'(bus4.req_ready), 64'd1);
        chk("rw.rst_valid", 64'(bus4.resp_valid), 64'd0);
        chk("rw.rst_mask", 64'(bus4.pmem_mask), 64'd0);
        chk("rw.rst_waddr", bus4.pmem_waddr, 64'd0);
        chk("rw.rst_wdata", bus4.pmem_wdata, 64'd0);
        chk("rw.rst_raddr", bus4.pmem_raddr, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        mk_n = 0; rv_cnt = 0;
        repeat (8) begin
            @(negedge clock);
            if (bus4.pmem_mask != 8'h00) mk_n++;
            if (bus4.resp_valid) rv_cnt++;
        end
        chk("rw.post_mask_cycles", 64'(mk_n), 64'd0);
        chk("rw.post_resp_cycles", 64'(rv_cnt), 64'd0);
        chk("rw.post_ready", 64'(bus4.req_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
